// File: rtl/dpmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpmem_arbiter_pkg
// Description : Shared types and constants for the dual-port memory arbiter:
//               requester index type, requester count and the value the
//               round-robin priority pointers take in reset.
// Revision    : 1.0 - initial release
// ============================================================================
package dpmem_arbiter_pkg;

  // Index of a requester (0 or 1)
  typedef logic req_idx_t;

  // Number of requesters sharing each memory port
  localparam int unsigned c_num_req = 2;

  // Priority pointer value after reset: requester 0 wins first contention
  localparam req_idx_t c_ptr_rst = 1'b0;

endpackage : dpmem_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. Grants are combinational from
//               the same-cycle requests; the priority pointer moves to the
//               requester that was not granted whenever a grant is issued and
//               holds otherwise.
// Ports       : clk    - clock, pointer updates on rising edge
//               reset  - asynchronous active-high reset (pointer -> 0)
//               i_req  - request vector, bit N from requester N
//               o_gnt  - one-hot (or zero) grant vector
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import dpmem_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [c_num_req-1:0] i_req,
  output logic [c_num_req-1:0] o_gnt
);

  req_idx_t             r_ptr;
  logic [c_num_req-1:0] w_gnt;

  always_comb begin
    w_gnt = '0;
    case (i_req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      // Contention: the pointer holder wins
      2'b11:   w_gnt = (r_ptr == 1'b1) ? 2'b10 : 2'b01;
      default: w_gnt = '0;
    endcase
  end

  // After a grant, priority passes to the other requester. w_gnt[1] is the
  // granted index whenever any grant is active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= c_ptr_rst;
    end else if (|w_gnt) begin
      r_ptr <= ~w_gnt[1];
    end
  end

  assign o_gnt = w_gnt;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dpmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dpmem_arbiter
// Description : Arbitrates two write requesters and two read requesters onto
//               an external dual-port memory with registered (one-cycle) read
//               data. Write and read ports use independent round-robin
//               arbiters. Read results come back one cycle after the grant
//               tagged with the owning requester.
// Config      : DPMEM_ARB_WR_FWD_EN - when defined, a read granted in the
//               same cycle as a write to the same address returns the new
//               write data; otherwise it returns the old memory contents.
// Ports       : clk, reset                 - clock, async active-high reset
//               wN_req/wN_adr/wN_dat/wN_gnt - write requester N (N=0,1)
//               rN_req/rN_adr/rN_gnt        - read requester N
//               r_valid/r_id/r_dat          - read response
//               mem_wr_en/mem_wr_adr/mem_dat_in/mem_rd_adr - memory drive
//               mem_dat_out                 - memory registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dpmem_arbiter
  import dpmem_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w0_req,
  input  logic [ADDR_SIZE-1:0] w0_adr,
  input  logic [DATA_SIZE-1:0] w0_dat,
  output logic                 w0_gnt,
  input  logic                 w1_req,
  input  logic [ADDR_SIZE-1:0] w1_adr,
  input  logic [DATA_SIZE-1:0] w1_dat,
  output logic                 w1_gnt,
  input  logic                 r0_req,
  input  logic [ADDR_SIZE-1:0] r0_adr,
  output logic                 r0_gnt,
  input  logic                 r1_req,
  input  logic [ADDR_SIZE-1:0] r1_adr,
  output logic                 r1_gnt,
  output logic                 r_valid,
  output logic                 r_id,
  output logic [DATA_SIZE-1:0] r_dat,
  output logic                 mem_wr_en,
  output logic [ADDR_SIZE-1:0] mem_wr_adr,
  output logic [DATA_SIZE-1:0] mem_dat_in,
  output logic [ADDR_SIZE-1:0] mem_rd_adr,
  input  logic [DATA_SIZE-1:0] mem_dat_out
);

  logic [c_num_req-1:0] w_wgnt;
  logic [c_num_req-1:0] w_rgnt;
  logic                 r_rvalid;
  req_idx_t             r_rid;

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .i_req ({w1_req, w0_req}),
    .o_gnt (w_wgnt)
  );

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .i_req ({r1_req, r0_req}),
    .o_gnt (w_rgnt)
  );

  assign w0_gnt = w_wgnt[0];
  assign w1_gnt = w_wgnt[1];
  assign r0_gnt = w_rgnt[0];
  assign r1_gnt = w_rgnt[1];

  // Memory side: granted requester's address/data, all zero when idle
  assign mem_wr_en  = |w_wgnt;
  assign mem_wr_adr = w_wgnt[1] ? w1_adr : (w_wgnt[0] ? w0_adr : '0);
  assign mem_dat_in = w_wgnt[1] ? w1_dat : (w_wgnt[0] ? w0_dat : '0);
  assign mem_rd_adr = w_rgnt[1] ? r1_adr : (w_rgnt[0] ? r0_adr : '0);

  // Response tag tracks the memory's one-cycle read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rid    <= 1'b0;
    end else begin
      r_rvalid <= |w_rgnt;
      if (|w_rgnt) begin
        r_rid <= w_rgnt[1];
      end
    end
  end

  assign r_valid = r_rvalid;
  assign r_id    = r_rid;

`ifdef DPMEM_ARB_WR_FWD_EN
  // The memory reads old data on a same-address collision; capture the
  // write data and substitute it in the response cycle.
  logic                 r_fwd_hit;
  logic [DATA_SIZE-1:0] r_fwd_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_hit <= 1'b0;
      r_fwd_dat <= '0;
    end else begin
      r_fwd_hit <= mem_wr_en && (|w_rgnt) && (mem_wr_adr == mem_rd_adr);
      r_fwd_dat <= mem_dat_in;
    end
  end

  assign r_dat = r_fwd_hit ? r_fwd_dat : mem_dat_out;
`else
  assign r_dat = mem_dat_out;
`endif

endmodule : dpmem_arbiter
`default_nettype wire

// File: doc/dpmem_arbiter.md
DPMEM_ARBITER -- requirements
Module: dpmem_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 16, shall set the memory data width.
REQ-002 Parameter ADDR_SIZE, default 16, shall set the memory address width.
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  shall be the asynchronous, active-high reset.
REQ-005 wN_req  input  1  (N=0,1) shall be the write request from requester N.
REQ-006 wN_adr  input  ADDR_SIZE  shall be the write address from requester N.
REQ-007 wN_dat  input  DATA_SIZE  shall be the write data from requester N.
REQ-008 wN_gnt  output  1  shall be the write grant to requester N; write completes in the granted cycle.
REQ-009 rN_req  input  1  shall be the read request from requester N.
REQ-010 rN_adr  input  ADDR_SIZE  shall be the read address from requester N.
REQ-011 rN_gnt  output  1  shall be the read grant to requester N.
REQ-012 r_valid  output  1  shall flag r_dat/r_id valid, one cycle after a read grant.
REQ-013 r_id  output  1  shall be the index of the requester owning r_dat.
REQ-014 r_dat  output  DATA_SIZE  shall be the read data.
REQ-015 mem_wr_en, mem_wr_adr, mem_dat_in, mem_rd_adr  outputs shall drive the dual-port memory's write enable, write address, write data and read address.
REQ-016 mem_dat_out  input  DATA_SIZE  shall be the memory's registered read data (one-cycle latency).

Function
REQ-017 Write and read ports shall be arbitrated independently, each by a two-way round-robin arbiter; grants shall be combinational from same-cycle requests.
REQ-018 Only one requester asserting: it shall be granted that cycle.
REQ-019 Both asserting: the holder of the priority pointer shall be granted; the pointer shall then move to the other requester.
REQ-020 Pointer shall change only on a grant; with no requests it shall hold.
REQ-021 A continuously requesting requester shall be granted within 2 cycles.
REQ-022 At most one of w0_gnt/w1_gnt, and one of r0_gnt/r1_gnt, shall be high in any cycle.
REQ-023 mem_wr_en shall equal w0_gnt|w1_gnt; mem_wr_adr/mem_dat_in shall be the granted requester's; all zero when no grant.
REQ-024 mem_rd_adr shall be the granted reader's address; zero when no read grant.
REQ-025 r_valid and r_id shall be registered from the read grant; r_dat shall equal mem_dat_out in the r_valid cycle.
REQ-026 A write and a read to the same address in the same cycle shall return the old data (unless REQ-030 applies).
REQ-027 Requests withdrawn before grant shall leave no state.

Reset
REQ-028 While reset is high: both priority pointers to requester 0, r_valid=0, r_id=0, forward registers cleared; memory contents not initialised.
REQ-029 Reset asserted mid-read shall suppress the pending r_valid.

Configuration
REQ-030 With DPMEM_ARB_WR_FWD_EN defined: same-cycle same-address write/read shall return the new write data on r_dat; without it, REQ-026 behaviour, with no forwarding logic present.

Structure
REQ-031 A shared package shall hold the requester-index type, the requester count (2), and the reset pointer value.
REQ-032 One sub-module, rr_arb2 (two-way round-robin arbiter with pointer register), shall be instantiated twice (write, read).

Verification
REQ-033 After reset, w0_req=w1_req=1 for 4 cycles -> grants alternate 0,1,0,1; mem_wr_en=1 each cycle.
REQ-034 Only r1_req=1, r1_adr=0x0010 with memory[0x0010]=0xBEEF -> r1_gnt same cycle; next cycle r_valid=1, r_id=1, r_dat=0xBEEF.
REQ-035 Write 0x1234 to 0x0005 and read 0x0005 same cycle -> r_dat=old value without macro, 0x1234 with DPMEM_ARB_WR_FWD_EN.
REQ-036 Read granted, reset pulsed before next edge -> r_valid stays 0; pointers return to requester 0.
REQ-037 No requests for 3 cycles -> no grants, mem_wr_en=0, mem addresses/data 0, r_valid=0; pointer unchanged.
